// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data memory between
// the IF stage (fetch, read-only) and the MEM stage (load/store).
// One access is in flight at a time: IDLE -> ISSUE -> (WAIT -> RESP) -> IDLE.
// The data port wins ties; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants made while a fetch was waiting.
// Optional build macro ARB_STATS_EN adds saturating grant/conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,   // 1..7
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // Data requester
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // Memory interface
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       stat_if_cnt,
  output logic [15:0]       stat_dm_cnt,
  output logic [15:0]       stat_conf_cnt,
`endif
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [2:0] WAIT_LOAD  = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  logic [1:0]        state_q,     state_d;
  logic [2:0]        wait_cnt_q,  wait_cnt_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              owner_q,     owner_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;

  logic idle;
  logic starve_hit;

  assign idle       = (state_q == S_IDLE);
  assign starve_hit = if_req && (starve_cnt_q == STARVE_TOP);

  // Grant decode: only in IDLE, data first unless a waiting fetch has starved.
  // Gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    dm_gnt = rst_n && idle && dm_req && !starve_hit;
    if_gnt = rst_n && idle && if_req && !(dm_req && !starve_hit);
  end

  // Next-state logic for the access sequencer, starvation counter and outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (dm_gnt) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            if (starve_cnt_q != STARVE_TOP) starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (if_gnt) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_IF;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          starve_cnt_d = 4'd0;
        end else if (!if_req) begin
          starve_cnt_d = 4'd0;
        end
      end

      S_ISSUE: begin
        // Stores complete at the memory edge; only reads wait for data.
        if (mem_we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = S_RESP;
          if (owner_q == OWN_DM) begin
            dm_rdata_d  = mem_rdata;
            dm_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end

      default: begin // S_RESP: the rvalid register is high this cycle
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 3'd0;
      starve_cnt_q <= 4'd0;
      owner_q      <= OWN_IF;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = !idle;

`ifdef ARB_STATS_EN
  logic [15:0] stat_if_q, stat_dm_q, stat_conf_q;

  // Saturating counters: fetch grants, data grants, IDLE cycles with both requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_q   <= '0;
      stat_dm_q   <= '0;
      stat_conf_q <= '0;
    end else begin
      if (if_gnt && stat_if_q != 16'hFFFF) stat_if_q <= stat_if_q + 16'd1;
      if (dm_gnt && stat_dm_q != 16'hFFFF) stat_dm_q <= stat_dm_q + 16'd1;
      if (idle && if_req && dm_req && stat_conf_q != 16'hFFFF)
        stat_conf_q <= stat_conf_q + 16'd1;
    end
  end

  assign stat_if_cnt   = stat_if_q;
  assign stat_dm_cnt   = stat_dm_q;
  assign stat_conf_cnt = stat_conf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 backed by a
// behavioural memory, one at MEM_LAT=3 whose read data is driven by hand.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance with default latency
  logic          if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_if_cnt, stat_dm_cnt, stat_conf_cnt;
`endif

  // Instance with MEM_LAT=3 (fetch port only exercised)
  logic          if3_req, if3_gnt, if3_rvalid, dm3_gnt, dm3_rvalid;
  logic [AW-1:0] if3_addr, mem3_addr;
  logic [DW-1:0] if3_rdata, dm3_rdata, mem3_wdata, mem3_rdata;
  logic          mem3_en, mem3_we, busy3;
`ifdef ARB_STATS_EN
  logic [15:0]   s3_if, s3_dm, s3_conf;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
    .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt), .stat_conf_cnt(stat_conf_cnt),
`endif
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt),
    .if_rvalid(if3_rvalid), .if_rdata(if3_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
    .dm_gnt(dm3_gnt), .dm_rvalid(dm3_rvalid), .dm_rdata(dm3_rdata),
    .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata),
`ifdef ARB_STATS_EN
    .stat_if_cnt(s3_if), .stat_dm_cnt(s3_dm), .stat_conf_cnt(s3_conf),
`endif
    .busy(busy3)
  );

  // Behavioural single-port memory, one-cycle read latency
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_order [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  logic [1:0] who;
  bit         got;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 32'h2801000A;
    mem_rdata = '0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if3_req = 0; if3_addr = '0; mem3_rdata = '0;

    // ---------------- reset state ----------------
    #12;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_dm_rvalid", dm_rvalid, 0);
    check("rst_if_rdata", if_rdata, 0);
    if_req = 1;
    #1 check("rst_if_gnt_gated", if_gnt, 0);
    if_req = 0;
    @(posedge clk); #1 rst_n = 1;
    next_cycle();

    // ---------------- single fetch ----------------
    if_req = 1; if_addr = 10'd5;
    #2 check("f_gnt_c0", if_gnt, 1); check("f_dmgnt_c0", dm_gnt, 0); check("f_busy_c0", busy, 0);
    next_cycle(); if_req = 0;
    #2 check("f_mem_en_c1", mem_en, 1); check("f_addr_c1", mem_addr, 5);
    check("f_we_c1", mem_we, 0); check("f_busy_c1", busy, 1); check("f_gnt_c1", if_gnt, 0);
    next_cycle();
    #2 check("f_mem_en_c2", mem_en, 0); check("f_rvalid_c2", if_rvalid, 0); check("f_busy_c2", busy, 1);
    next_cycle();
    #2 check("f_rvalid_c3", if_rvalid, 1); check("f_rdata_c3", if_rdata, 32'h2801000A);
    check("f_busy_c3", busy, 1);
    next_cycle();
    #2 check("f_rvalid_c4", if_rvalid, 0); check("f_busy_c4", busy, 0);

    // ---------------- store then load ----------------
    next_cycle();
    dm_req = 1; dm_we = 1; dm_addr = 10'd12; dm_wdata = 32'hDEADBEEF;
    #2 check("sl_gnt_c0", dm_gnt, 1);
    next_cycle(); dm_we = 0;
    #2 check("sl_mem_en_c1", mem_en, 1); check("sl_we_c1", mem_we, 1);
    check("sl_wdata_c1", mem_wdata, 32'hDEADBEEF); check("sl_addr_c1", mem_addr, 12);
    check("sl_gnt_c1", dm_gnt, 0); check("sl_rvalid_c1", dm_rvalid, 0);
    next_cycle();
    #2 check("sl_gnt_c2", dm_gnt, 1); check("sl_rvalid_c2", dm_rvalid, 0);
    next_cycle(); dm_req = 0;
    #2 check("sl_we_c3", mem_we, 0); check("sl_rvalid_c3", dm_rvalid, 0);
    next_cycle();
    #2 check("sl_rvalid_c4", dm_rvalid, 0);
    next_cycle();
    #2 check("sl_rvalid_c5", dm_rvalid, 1); check("sl_rdata_c5", dm_rdata, 32'hDEADBEEF);
    check("sl_if_rdata_kept", if_rdata, 32'h2801000A); check("sl_if_rvalid_c5", if_rvalid, 0);
    next_cycle();

    // ---------------- conflict / starvation ----------------
    next_cycle();
    if_req = 1; if_addr = 10'd5; dm_req = 1; dm_we = 0; dm_addr = 10'd12;
    for (int k = 0; k < 10; k++) begin
      got = 0;
      for (int c = 0; c < 12; c++) begin
        #2 who = {dm_gnt, if_gnt};
        if (who != 2'b00) begin
          check($sformatf("conf_order%0d", k), 32'(who), 32'(exp_order[k]));
          got = 1;
        end
        next_cycle();
        if (got) break;
      end
      if (!got) check($sformatf("conf_timeout%0d", k), 0, 1);
    end
    if_req = 0; dm_req = 0;
    repeat (6) next_cycle();

    // ---------------- MEM_LAT=3 ----------------
    if3_req = 1; if3_addr = 10'd7; mem3_rdata = 32'hBAD0BAD0;
    #2 check("l3_gnt_c0", if3_gnt, 1);
    next_cycle(); if3_req = 0;
    #2 check("l3_mem_en_c1", mem3_en, 1);
    next_cycle();
    #2 check("l3_rvalid_c2", if3_rvalid, 0);
    next_cycle(); mem3_rdata = 32'hBAD1BAD1;
    #2 check("l3_rvalid_c3", if3_rvalid, 0);
    next_cycle(); mem3_rdata = 32'h12345678;
    #2 check("l3_rvalid_c4", if3_rvalid, 0); check("l3_busy_c4", busy3, 1);
    next_cycle(); mem3_rdata = 32'hBAD2BAD2;
    #2 check("l3_rvalid_c5", if3_rvalid, 1); check("l3_rdata_c5", if3_rdata, 32'h12345678);
    next_cycle();
    #2 check("l3_rvalid_c6", if3_rvalid, 0); check("l3_busy_c6", busy3, 0);

    // ---------------- reset mid-operation ----------------
    next_cycle();
    if_req = 1; if_addr = 10'd5;
    #2 check("rm_gnt_c0", if_gnt, 1);
    next_cycle(); if_req = 0;
    next_cycle();
    #2 rst_n = 0;
    #1 check("rm_busy", busy, 0); check("rm_mem_en", mem_en, 0);
    check("rm_mem_addr", mem_addr, 0); check("rm_if_rvalid", if_rvalid, 0);
    if_req = 1;
    #1 check("rm_gnt_in_rst", if_gnt, 0);
    next_cycle();
    #2 check("rm_no_rvalid_rst", if_rvalid, 0);
    next_cycle(); rst_n = 1;
    #2 check("rm_gnt_first_idle", if_gnt, 1); check("rm_busy_idle", busy, 0);
    next_cycle(); if_req = 0;
    #2 check("rm_no_rvalid_a", if_rvalid, 0);
    next_cycle();
    #2 check("rm_no_rvalid_b", if_rvalid, 0);
    next_cycle();
    #2 check("rm_rvalid_new", if_rvalid, 1); check("rm_rdata_new", if_rdata, 32'h2801000A);
    next_cycle();

`ifdef ARB_STATS_EN
    // ---------------- statistics ----------------
    rst_n = 0;
    next_cycle(); rst_n = 1;
    if_req = 1; if_addr = 10'd5; dm_req = 1; dm_we = 0; dm_addr = 10'd12;
    #2 check("st_dm_first", dm_gnt, 1);
    next_cycle(); dm_req = 0;
    for (int n = 0; n < 3; n++) begin
      got = 0;
      for (int c = 0; c < 8; c++) begin
        #2 if (if_gnt) got = 1;
        next_cycle();
        if (got) break;
      end
      if (!got) check($sformatf("st_if_timeout%0d", n), 0, 1);
    end
    if_req = 0;
    repeat (5) next_cycle();
    check("st_conf", stat_conf_cnt, 1);
    check("st_dm", stat_dm_cnt, 1);
    check("st_if", stat_if_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
